// File: rtl/conv_sched_pkg.sv
// Shared FSM state type, engine encodings and descriptor layout for conv_layer_sched.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_B, LATCH, START, RUN, NEXT, DONE
  } state_e;

  localparam logic ENG_1X1 = 1'b0;
  localparam logic ENG_3X3 = 1'b1;

  // Each layer owns two consecutive words: config (engine select in bit 0), then w8.
  localparam int unsigned DESC_SEL_BIT  = 0;
  localparam logic        DESC_WORD_CFG = 1'b0;
  localparam logic        DESC_WORD_W8  = 1'b1;

  function automatic logic [5:0] desc_addr_of(input logic [4:0] idx, input logic word);
    return {idx, word};
  endfunction

endpackage

// File: rtl/conv_sched_wdog.sv
// RUN-state watchdog: counts consecutive cycles with run_i high and flags the last allowed one.
module conv_sched_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High during the TIMEOUT_CYCLES-th RUN cycle; the scheduler leaves RUN on it.
  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: fetches two-word descriptors, starts the 1x1/3x3 engine, waits for finish.
// Optional RUN watchdog compiled in with CONV_SCHED_TIMEOUT_EN.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [4:0]  num_layers,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  layer_idx,
  output logic        desc_cs,
  output logic [5:0]  desc_addr,
  input  logic [31:0] desc_rdata,
  output logic [1:0]  eng_start,
  output logic [31:0] eng_w8,
  input  logic [1:0]  eng_finish
);

  state_e      state_q, state_d;
  logic [4:0]  layer_idx_q, layer_idx_d;
  logic [4:0]  num_layers_q;
  logic        sel_q;
  logic [31:0] eng_w8_q;
  logic        busy_q, done_q, desc_cs_q;
  logic [5:0]  desc_addr_q, desc_addr_d;
  logic [1:0]  eng_start_q, eng_start_d;

  logic accept, finish_ok, last_layer, timeout;

  assign accept     = (state_q == IDLE) && run;
  assign finish_ok  = eng_finish[sel_q];
  assign last_layer = (layer_idx_q == num_layers_q - 5'd1);

`ifdef CONV_SCHED_TIMEOUT_EN
  logic wdog_expired;
  logic err_q;

  conv_sched_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == RUN),
    .expired_o(wdog_expired)
  );

  assign timeout = (state_q == RUN) && !finish_ok && wdog_expired;
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          layer_idx_d = '0;
          state_d     = (num_layers == 5'd0) ? DONE : FETCH_A;
        end
      end
      FETCH_A: state_d = FETCH_B;
      FETCH_B: state_d = LATCH;
      LATCH:   state_d = START;
      START:   state_d = RUN;
      RUN: begin
        if (finish_ok)    state_d = last_layer ? DONE : NEXT;
        else if (timeout) state_d = DONE;
      end
      NEXT: begin
        layer_idx_d = layer_idx_q + 5'd1;
        state_d     = FETCH_A;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they belong to.
  always_comb begin
    desc_addr_d = '0;
    if (state_d == FETCH_A) desc_addr_d = desc_addr_of(layer_idx_d, DESC_WORD_CFG);
    if (state_d == FETCH_B) desc_addr_d = desc_addr_of(layer_idx_d, DESC_WORD_W8);
    eng_start_d = '0;
    if (state_d == START) eng_start_d = (sel_q == ENG_3X3) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only; the datapath captures are
      // reset as well so an aborted schedule leaves nothing stale on eng_w8.
      state_q      <= IDLE;
      layer_idx_q  <= '0;
      num_layers_q <= '0;
      sel_q        <= ENG_1X1;
      eng_w8_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      desc_cs_q    <= 1'b0;
      desc_addr_q  <= '0;
      eng_start_q  <= '0;
`ifdef CONV_SCHED_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      desc_cs_q   <= (state_d == FETCH_A) || (state_d == FETCH_B);
      desc_addr_q <= desc_addr_d;
      eng_start_q <= eng_start_d;
      if (accept)             num_layers_q <= num_layers;
      if (state_q == FETCH_B) sel_q        <= desc_rdata[DESC_SEL_BIT];
      if (state_q == LATCH)   eng_w8_q     <= desc_rdata;
`ifdef CONV_SCHED_TIMEOUT_EN
      if (accept)       err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign layer_idx = layer_idx_q;
  assign desc_cs   = desc_cs_q;
  assign desc_addr = desc_addr_q;
  assign eng_start = eng_start_q;
  assign eng_w8    = eng_w8_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: stimulus pushes expected output events, a monitor pops them.
module tb_conv_layer_sched;

  typedef enum int {EV_CS, EV_START, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] w8;
    logic [4:0]  idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [4:0]  num_layers;
  logic        busy, done, err;
  logic [4:0]  layer_idx;
  logic        desc_cs;
  logic [5:0]  desc_addr;
  logic [31:0] desc_rdata = '0;
  logic [1:0]  eng_start;
  logic [31:0] eng_w8;
  logic [1:0]  eng_finish;

  logic [31:0] mem [0:63];
  ev_t         sb [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  conv_layer_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .num_layers(num_layers),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .layer_idx (layer_idx),
    .desc_cs   (desc_cs),
    .desc_addr (desc_addr),
    .desc_rdata(desc_rdata),
    .eng_start (eng_start),
    .eng_w8    (eng_w8),
    .eng_finish(eng_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (desc_cs) desc_rdata <= mem[desc_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_e k, input int c, input logic [31:0] a,
                      input logic [31:0] w, input logic [4:0] idx);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.w8 = w; e.idx = idx;
    sb.push_back(e);
  endtask

  // Expected events for one layer whose START lands in cycle s.
  task automatic push_layer(input int s, input logic [4:0] idx, input logic [1:0] st,
                            input logic [31:0] w);
    push(EV_CS, s - 3, {25'd0, idx, 1'b0}, '0, idx);
    push(EV_CS, s - 2, {25'd0, idx, 1'b1}, '0, idx);
    push(EV_START, s, {30'd0, st}, w, idx);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic pulse_finish(input logic [1:0] f);
    eng_finish = f;
    tick(1);
    eng_finish = 2'b00;
  endtask

  task automatic start_run(input logic [4:0] n);
    run = 1'b1;
    num_layers = n;
    tick(1);
    run = 1'b0;
  endtask

  // Monitor: any cycle with an observable event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (desc_cs || eng_start != 2'b00 || done) begin
      ev_kind_e act_kind;
      act_kind = desc_cs ? EV_CS : (eng_start != 2'b00) ? EV_START : EV_DONE;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d with empty scoreboard (cycle %0d)",
                 act_kind, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_kind", act_kind, e.kind);
        check("ev_cycle", cyc, e.cyc);
        case (e.kind)
          EV_CS: begin
            check("desc_addr", {26'd0, desc_addr}, e.a);
            check("cs_layer_idx", {27'd0, layer_idx}, {27'd0, e.idx});
          end
          EV_START: begin
            check("eng_start", {30'd0, eng_start}, e.a);
            check("eng_w8", eng_w8, e.w8);
            check("start_layer_idx", {27'd0, layer_idx}, {27'd0, e.idx});
          end
          default: begin
            check("done_err", {31'd0, err}, e.a);
            check("done_busy", {31'd0, busy}, 32'd1);
          end
        endcase
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [31:0] w8_tab [4];
    logic [1:0]  st_tab [4];
    w8_tab = '{32'h7F3F10F0, 32'h01020304, 32'h33333333, 32'h44444444};
    st_tab = '{2'b01, 2'b10, 2'b01, 2'b10};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h12345670; mem[1] = 32'h7F3F10F0;   // layer 0: 1x1
    mem[2] = 32'hDEADBEE1; mem[3] = 32'h01020304;   // layer 1: 3x3 (upper bits ignored)
    mem[4] = 32'h00000000; mem[5] = 32'h33333333;   // layer 2: 1x1
    mem[6] = 32'h00000003; mem[7] = 32'h44444444;   // layer 3: 3x3

    rst = 1'b1; run = 1'b0; num_layers = '0; eng_finish = '0;
    tick(2);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_desc_cs", {31'd0, desc_cs}, 0);
    check("rst_eng_start", {30'd0, eng_start}, 0);
    check("rst_eng_w8", eng_w8, 0);
    rst = 1'b0;
    tick(2);

    // Two layers, 10-cycle engines; busy-time run and num_layers change must be ignored.
    k = cyc;
    push_layer(k + 4, 5'd0, 2'b01, 32'h7F3F10F0);
    push_layer(k + 19, 5'd1, 2'b10, 32'h01020304);
    push(EV_DONE, k + 30, 0, '0, 5'd1);
    start_run(5'd2);
    check("busy_after_accept", {31'd0, busy}, 1);
    wait_cyc(k + 6);
    start_run(5'd5);
    wait_cyc(k + 10);
    check("w8_hold_in_run", eng_w8, 32'h7F3F10F0);
    wait_cyc(k + 14); pulse_finish(2'b01);
    wait_cyc(k + 19); pulse_finish(2'b10);   // sampled in START: ignored
    wait_cyc(k + 29); pulse_finish(2'b10);
    wait_cyc(k + 31);
    check("idle_after_sched", {31'd0, busy}, 0);

    // Zero layers: straight to DONE.
    tick(2);
    k = cyc;
    push(EV_DONE, k + 1, 0, '0, 5'd0);
    start_run(5'd0);
    wait_cyc(k + 3);
    check("zero_layers_idle", {31'd0, busy}, 0);

    // Wrong-engine finish during a 1x1 layer is ignored.
    tick(2);
    k = cyc;
    push_layer(k + 4, 5'd0, 2'b01, 32'h7F3F10F0);
    push(EV_DONE, k + 11, 0, '0, 5'd0);
    start_run(5'd1);
    wait_cyc(k + 7); pulse_finish(2'b10);
    wait_cyc(k + 9);
    check("wrong_finish_busy", {31'd0, busy}, 1);
    wait_cyc(k + 10); pulse_finish(2'b01);
    wait_cyc(k + 13);
    check("after_correct_finish", {31'd0, busy}, 0);

    // Reset mid-RUN of layer 3 aborts silently; a new run restarts at layer 0.
    tick(2);
    k = cyc;
    for (int i = 0; i < 4; i++) push_layer(k + 4 + 8 * i, 5'(i), st_tab[i], w8_tab[i]);
    start_run(5'd5);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(k + 7 + 8 * i);
      pulse_finish((i % 2) != 0 ? 2'b10 : 2'b01);
    end
    wait_cyc(k + 31);
    check("pre_rst_layer_idx", {27'd0, layer_idx}, 3);
    rst = 1'b1;
    tick(1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_desc_cs", {31'd0, desc_cs}, 0);
    check("abort_desc_addr", {26'd0, desc_addr}, 0);
    check("abort_eng_start", {30'd0, eng_start}, 0);
    check("abort_eng_w8", eng_w8, 0);
    check("abort_layer_idx", {27'd0, layer_idx}, 0);
    rst = 1'b0;
    tick(4);
    k = cyc;
    push_layer(k + 4, 5'd0, 2'b01, 32'h7F3F10F0);
    push(EV_DONE, k + 7, 0, '0, 5'd0);
    start_run(5'd1);
    wait_cyc(k + 6); pulse_finish(2'b01);
    wait_cyc(k + 9);

`ifdef CONV_SCHED_TIMEOUT_EN
    // No finish: 16 RUN cycles then DONE with err; next accepted run clears err.
    k = cyc;
    push_layer(k + 4, 5'd0, 2'b01, 32'h7F3F10F0);
    push(EV_DONE, k + 21, 1, '0, 5'd0);
    start_run(5'd1);
    wait_cyc(k + 22);
    check("timeout_err_set", {31'd0, err}, 1);
    wait_cyc(k + 25);
    check("timeout_err_sticky", {31'd0, err}, 1);
    k = cyc;
    push_layer(k + 4, 5'd0, 2'b01, 32'h7F3F10F0);
    push(EV_DONE, k + 7, 0, '0, 5'd0);
    start_run(5'd1);
    check("err_cleared_by_run", {31'd0, err}, 0);
    wait_cyc(k + 6); pulse_finish(2'b01);
    wait_cyc(k + 9);
`else
    check("err_tied_low", {31'd0, err}, 0);
`endif

    tick(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
